// File: rtl/rvh_l1d_mshr_pool.sv
// L1D miss-status holding register pool: slot allocation, in-order L2 AR issue, flush tracking.
// Optional address-match lookup enabled by defining RVH_L1D_MSHR_ADDR_MATCH_EN.
module rvh_l1d_mshr_pool #(
  parameter int N_MSHR      = 4,
  parameter int LINE_ADDR_W = 50,
  parameter int PAYLOAD_W   = 64,
  parameter int BANK_ID     = 0,
  localparam int IDW        = (N_MSHR > 1) ? $clog2(N_MSHR) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  output logic [IDW-1:0]                alloc_id_o,
  input  logic [LINE_ADDR_W-1:0]        alloc_paddr_i,
  input  logic                          alloc_need_fetch_i,
  input  logic [PAYLOAD_W-1:0]          alloc_payload_i,
  input  logic [LINE_ADDR_W-1:0]        lookup_paddr_i,
  output logic                          lookup_hit_o,
  output logic [IDW-1:0]                lookup_id_o,
  input  logic                          dealloc_valid_i,
  input  logic [IDW-1:0]                dealloc_id_i,
  input  logic                          rob_flush_i,
  output logic                          l2_arvalid_o,
  input  logic                          l2_arready_i,
  output logic [LINE_ADDR_W+5:0]        l2_ar_addr_o,
  output logic [7:0]                    l2_ar_id_o,
  output logic [7:0]                    l2_ar_len_o,
  output logic [2:0]                    l2_ar_size_o,
  output logic [1:0]                    l2_ar_burst_o,
  output logic [N_MSHR-1:0]             slot_valid_o,
  output logic [N_MSHR-1:0]             slot_sent_o,
  output logic [N_MSHR-1:0]             slot_no_resp_o,
  output logic [N_MSHR*PAYLOAD_W-1:0]   slot_payload_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CW = $clog2(N_MSHR + 1);
  localparam logic [3:0] BANK_NIB = 4'(BANK_ID);

  logic [N_MSHR-1:0]      valid_q, sent_q, no_resp_q;
  logic [LINE_ADDR_W-1:0] addr_q    [N_MSHR];
  logic [PAYLOAD_W-1:0]   payload_q [N_MSHR];
  logic [IDW-1:0]         iq_q      [N_MSHR];
  logic [IDW-1:0]         head_q, tail_q;
  logic [CW-1:0]          cnt_q;

  logic [IDW-1:0]    free_id;
  logic [IDW-1:0]    head_slot;
  logic [N_MSHR-1:0] alloc_onehot;
  logic              alloc_fire, push, pop, head_live, ar_fire;

  // Lowest-index free slot, derived from registered valid bits only.
  always_comb begin
    free_id = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_id = IDW'(i);
    end
  end

  assign full_o        = &valid_q;
  assign empty_o       = ~|valid_q;
  assign alloc_ready_o = ~full_o;
  assign alloc_id_o    = free_id;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign alloc_onehot  = alloc_fire ? (N_MSHR'(1) << free_id) : '0;
  assign push          = alloc_fire & alloc_need_fetch_i;

  // A head entry whose slot was freed (or already sent) is stale and pops without an AR.
  assign head_slot    = iq_q[head_q];
  assign head_live    = valid_q[head_slot] & ~sent_q[head_slot];
  assign l2_arvalid_o = (cnt_q != '0) & head_live;
  assign ar_fire      = l2_arvalid_o & l2_arready_i;
  assign pop          = (cnt_q != '0) & (~head_live | l2_arready_i);

  assign l2_ar_addr_o  = {addr_q[head_slot], 6'b0};
  assign l2_ar_id_o    = {BANK_NIB, 4'(head_slot)};
  assign l2_ar_len_o   = 8'd7;
  assign l2_ar_size_o  = 3'd3;
  assign l2_ar_burst_o = 2'b01;

  assign slot_valid_o   = valid_q;
  assign slot_sent_o    = sent_q;
  assign slot_no_resp_o = no_resp_q;

  always_comb begin
    slot_payload_o = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      slot_payload_o[i*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
    end
  end

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(N_MSHR - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      sent_q    <= '0;
      no_resp_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (dealloc_valid_i) valid_q[dealloc_id_i] <= 1'b0;
      if (ar_fire) sent_q[head_slot] <= 1'b1;
      if (alloc_fire) begin
        valid_q[free_id]   <= 1'b1;
        sent_q[free_id]    <= 1'b0;
        no_resp_q[free_id] <= 1'b0;
      end
      // Flush overrides the no_resp clear of a slot allocated in the same cycle.
      if (rob_flush_i) no_resp_q <= no_resp_q | valid_q | alloc_onehot;
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[free_id]    <= alloc_paddr_i;
      payload_q[free_id] <= alloc_payload_i;
    end
    if (push) iq_q[tail_q] <= free_id;
  end

`ifdef RVH_L1D_MSHR_ADDR_MATCH_EN
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_id_o  = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == lookup_paddr_i)) begin
        lookup_hit_o = 1'b1;
        lookup_id_o  = IDW'(i);
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_paddr_i;
  assign lookup_hit_o  = 1'b0;
  assign lookup_id_o   = '0;
`endif

endmodule

// File: tb/tb_rvh_l1d_mshr_pool.sv
// Bench for rvh_l1d_mshr_pool: directed scenarios then random traffic against a queue-based model.
module tb_rvh_l1d_mshr_pool;
  localparam int N   = 4;
  localparam int AW  = 50;
  localparam int PW  = 64;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid_i, alloc_ready_o, alloc_need_fetch_i;
  logic [IDW-1:0]    alloc_id_o, lookup_id_o, dealloc_id_i;
  logic [AW-1:0]     alloc_paddr_i, lookup_paddr_i;
  logic [PW-1:0]     alloc_payload_i;
  logic              lookup_hit_o, dealloc_valid_i, rob_flush_i;
  logic              l2_arvalid_o, l2_arready_i;
  logic [AW+5:0]     l2_ar_addr_o;
  logic [7:0]        l2_ar_id_o, l2_ar_len_o;
  logic [2:0]        l2_ar_size_o;
  logic [1:0]        l2_ar_burst_o;
  logic [N-1:0]      slot_valid_o, slot_sent_o, slot_no_resp_o;
  logic [N*PW-1:0]   slot_payload_o;
  logic              full_o, empty_o;

  rvh_l1d_mshr_pool #(.N_MSHR(N), .LINE_ADDR_W(AW), .PAYLOAD_W(PW), .BANK_ID(0)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .alloc_paddr_i(alloc_paddr_i), .alloc_need_fetch_i(alloc_need_fetch_i),
    .alloc_payload_i(alloc_payload_i),
    .lookup_paddr_i(lookup_paddr_i), .lookup_hit_o(lookup_hit_o), .lookup_id_o(lookup_id_o),
    .dealloc_valid_i(dealloc_valid_i), .dealloc_id_i(dealloc_id_i), .rob_flush_i(rob_flush_i),
    .l2_arvalid_o(l2_arvalid_o), .l2_arready_i(l2_arready_i), .l2_ar_addr_o(l2_ar_addr_o),
    .l2_ar_id_o(l2_ar_id_o), .l2_ar_len_o(l2_ar_len_o), .l2_ar_size_o(l2_ar_size_o),
    .l2_ar_burst_o(l2_ar_burst_o),
    .slot_valid_o(slot_valid_o), .slot_sent_o(slot_sent_o), .slot_no_resp_o(slot_no_resp_o),
    .slot_payload_o(slot_payload_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-slot flags plus a queue of slot numbers awaiting an L2 read.
  logic [N-1:0]  m_valid, m_sent, m_nr;
  logic [AW-1:0] m_addr [N];
  logic [PW-1:0] m_pay  [N];
  int            fq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_free(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (!v[i]) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] pool_addr(input int k);
    if (k == 0) return 50'h1000;
    if (k == 7) return 50'h3_0000_0000_1000;
    return 50'h1000 + 50'(k) * 50'h40;
  endfunction

  task automatic model_clear();
    m_valid = '0; m_sent = '0; m_nr = '0;
    fq.delete();
  endtask

  task automatic check_all();
    int  ff, h, hit_id;
    bit  exp_arv, exp_hit;
    ff = first_free(m_valid);
    chk("alloc_ready", alloc_ready_o, ff >= 0);
    if (ff >= 0) chk("alloc_id", alloc_id_o, ff);
    chk("full", full_o, m_valid == '1);
    chk("empty", empty_o, m_valid == '0);
    chk("slot_valid", slot_valid_o, m_valid);
    chk("slot_sent", slot_sent_o, m_sent);
    chk("slot_no_resp", slot_no_resp_o, m_nr);
    exp_arv = 0;
    h = 0;
    if (fq.size() > 0) begin
      h = fq[0];
      exp_arv = m_valid[h] && !m_sent[h];
    end
    chk("arvalid", l2_arvalid_o, exp_arv);
    if (exp_arv) begin
      chk("ar_addr", l2_ar_addr_o, {m_addr[h], 6'b0});
      chk("ar_id", l2_ar_id_o, {4'h0, 4'(h)});
      chk("ar_len", l2_ar_len_o, 8'd7);
      chk("ar_size", l2_ar_size_o, 3'd3);
      chk("ar_burst", l2_ar_burst_o, 2'b01);
    end
    exp_hit = 0;
    hit_id  = 0;
`ifdef RVH_L1D_MSHR_ADDR_MATCH_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (m_valid[i] && m_addr[i] == lookup_paddr_i) begin
        exp_hit = 1;
        hit_id  = i;
      end
    end
`endif
    chk("lookup_hit", lookup_hit_o, exp_hit);
    if (exp_hit) chk("lookup_id", lookup_id_o, hit_id);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) chk("payload", slot_payload_o[i*PW +: PW], m_pay[i]);
    end
  endtask

  task automatic model_step(input bit av, input logic [AW-1:0] pa, input bit nf,
                            input logic [PW-1:0] pl, input bit dv, input int did,
                            input bit fl, input bit ar, input bit r);
    logic [N-1:0] ov;
    int idx, h;
    bit acc;
    if (r) begin
      model_clear();
      return;
    end
    ov  = m_valid;
    idx = first_free(ov);
    acc = av && (idx >= 0);
    if (fq.size() > 0) begin
      h = fq[0];
      if (ov[h] && !m_sent[h]) begin
        if (ar) begin
          m_sent[h] = 1'b1;
          void'(fq.pop_front());
        end
      end else begin
        void'(fq.pop_front());
      end
    end
    if (dv) m_valid[did] = 1'b0;
    if (acc) begin
      m_valid[idx] = 1'b1;
      m_sent[idx]  = 1'b0;
      m_nr[idx]    = 1'b0;
      m_addr[idx]  = pa;
      m_pay[idx]   = pl;
      if (nf) fq.push_back(idx);
    end
    if (fl) begin
      m_nr = m_nr | ov;
      if (acc) m_nr[idx] = 1'b1;
    end
  endtask

  // Drive one cycle: apply inputs at the falling edge, check, advance the model, wait a cycle.
  task automatic drive(input bit av, input logic [AW-1:0] pa, input bit nf, input bit dv,
                       input int did, input bit fl, input bit ar, input bit r);
    logic [PW-1:0] pl;
    pl = {$urandom, $urandom};
    rst                = r;
    alloc_valid_i      = av;
    alloc_paddr_i      = pa;
    alloc_need_fetch_i = nf;
    alloc_payload_i    = pl;
    lookup_paddr_i     = pool_addr($urandom_range(0, 7));
    dealloc_valid_i    = dv;
    dealloc_id_i       = IDW'(did);
    rob_flush_i        = fl;
    l2_arready_i       = ar;
    #1;
    check_all();
    model_step(av, pa, nf, pl, dv, did, fl, ar, r);
    @(negedge clk);
  endtask

  task automatic idle(input bit ar);
    drive(0, '0, 0, 0, 0, 0, ar, 0);
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid_i = 0; alloc_paddr_i = '0; alloc_need_fetch_i = 0; alloc_payload_i = '0;
    lookup_paddr_i = '0; dealloc_valid_i = 0; dealloc_id_i = '0; rob_flush_i = 0;
    l2_arready_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    #1;
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_alloc_id", alloc_id_o, 0);
    chk("rst_arvalid", l2_arvalid_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    @(negedge clk);

    // First miss issues a line-aligned read one cycle later.
    drive(1, 50'h1000, 1, 0, 0, 0, 0, 0);
    chk("first_arvalid", l2_arvalid_o, 1);
    chk("first_ar_addr", l2_ar_addr_o, 56'h40000);
    chk("first_ar_id", l2_ar_id_o, 8'h00);
    chk("first_ar_len", l2_ar_len_o, 8'd7);

    // Fill the pool with AR back-pressured, then drain in order.
    for (int i = 1; i < N; i++) drive(1, pool_addr(i), 1, 0, 0, 0, 0, 0);
    chk("fill_full", full_o, 1);
    chk("fill_ready", alloc_ready_o, 0);
    chk("fill_head", l2_ar_id_o, 8'h00);
    for (int i = 0; i < N; i++) begin
      chk("drain_id", l2_ar_id_o, 8'(i));
      idle(1);
    end
    chk("drain_sent", slot_sent_o, 4'hf);

    for (int i = 0; i < N; i++) drive(0, '0, 0, 1, i, 0, 0, 0);

    // Full-line write: slot valid but no read.
    drive(1, pool_addr(3), 0, 0, 0, 0, 1, 0);
    chk("nofetch_valid", slot_valid_o, 4'b0001);
    chk("nofetch_arvalid", l2_arvalid_o, 0);

    // Slot 1 freed before its read goes out; queue skips to slot 2.
    drive(1, pool_addr(1), 1, 0, 0, 0, 0, 0);
    drive(1, pool_addr(2), 1, 1, 1, 0, 0, 0);
    idle(0);
    chk("stale_skip_id", l2_ar_id_o, 8'h02);
    idle(1);

    // Flush with slots 0,2 valid and slot 1 allocated in the same cycle.
    drive(1, pool_addr(4), 1, 0, 0, 1, 0, 0);
    chk("flush_no_resp", slot_no_resp_o, 4'b0111);
    drive(0, '0, 0, 1, 0, 0, 0, 0);
    drive(1, pool_addr(5), 0, 0, 0, 0, 0, 0);
    chk("realloc_no_resp", slot_no_resp_o[0], 0);

    for (int c = 0; c < 2000; c++) begin
      bit av, nf, dv, fl, ar, r;
      av = $urandom_range(0, 99) < 55;
      nf = $urandom_range(0, 3) != 0;
      if (av && nf && fq.size() >= N) av = 0;
      dv = $urandom_range(0, 99) < 35;
      fl = $urandom_range(0, 99) < 5;
      ar = $urandom_range(0, 99) < 50;
      r  = $urandom_range(0, 299) == 0;
      drive(av, pool_addr($urandom_range(0, 7)), nf, dv, $urandom_range(0, N - 1), fl, ar, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
